// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath-control bundle between aes_round_ctrl and its neighbours.
// master: the round controller; slave: host, key schedule and round datapath.
interface aes_round_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic       key_req;
  logic       key_ack;
  logic [3:0] round_idx;
  logic       dp_load;
  logic       dp_sub_en;
  logic       dp_shift_en;
  logic       dp_mix_en;
  logic       dp_ark_en;
  logic       dp_capture;
  logic       busy;

  modport master (
    input  in_valid, out_ready, key_ack,
    output in_ready, out_valid, key_req, round_idx,
    output dp_load, dp_sub_en, dp_shift_en, dp_mix_en, dp_ark_en, dp_capture, busy
  );

  modport slave (
    output in_valid, out_ready, key_ack,
    input  in_ready, out_valid, key_req, round_idx,
    input  dp_load, dp_sub_en, dp_shift_en, dp_mix_en, dp_ark_en, dp_capture, busy
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: load, per-round key fetch, stage strobes, result handshake.
// Optional AES_CTRL_ABORT_EN adds an abort input that drops any in-flight block.
module aes_round_ctrl #(
  parameter int unsigned NR = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
`ifdef AES_CTRL_ABORT_EN
  input  logic             abort,
`endif
  aes_round_ctrl_if.master bus
);

  typedef enum logic [2:0] {StIdle, StLoad, StKeyWait, StRound, StDone} state_e;

  localparam logic [3:0] LastRound = 4'(NR);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : gen_nr_check
    $error("aes_round_ctrl: NR must be 10, 12 or 14");
  end

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic       abort_req;

`ifdef AES_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Abort outranks en; en low freezes everything, including pending key_ack.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    if (abort_req && (state_q != StIdle)) begin
      state_d = StIdle;
      round_d = '0;
    end else if (en) begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            state_d = StLoad;
            round_d = '0;
          end
        end
        StLoad: state_d = StKeyWait;
        StKeyWait: begin
          if (bus.key_ack) state_d = StRound;
        end
        StRound: begin
          if (round_q < LastRound) begin
            round_d = round_q + 4'd1;
            state_d = StKeyWait;
          end else begin
            state_d = StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_d = StIdle;
            round_d = '0;
          end
        end
        default: begin
          state_d = StIdle;
          round_d = '0;
        end
      endcase
    end
  end

  logic strobe_ok;
  assign strobe_ok = en && !abort_req;

  always_comb begin
    bus.in_ready    = 1'b0;
    bus.out_valid   = 1'b0;
    bus.key_req     = 1'b0;
    bus.dp_load     = 1'b0;
    bus.dp_sub_en   = 1'b0;
    bus.dp_shift_en = 1'b0;
    bus.dp_mix_en   = 1'b0;
    bus.dp_ark_en   = 1'b0;
    bus.dp_capture  = 1'b0;
    bus.round_idx   = round_q;
    bus.busy        = (state_q != StIdle);
    unique case (state_q)
      StIdle:    bus.in_ready = 1'b1;
      StLoad:    bus.dp_load  = strobe_ok;
      StKeyWait: bus.key_req  = 1'b1;
      StRound: begin
        // Round 0 is the whitening AddRoundKey; the last round skips MixColumns.
        if (strobe_ok) begin
          bus.dp_ark_en = 1'b1;
          if (round_q != 4'd0) begin
            bus.dp_sub_en   = 1'b1;
            bus.dp_shift_en = 1'b1;
            bus.dp_mix_en   = (round_q != LastRound);
            bus.dp_capture  = (round_q == LastRound);
          end
        end
      end
      StDone:    bus.out_valid = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: linear-step reference model, directed scenarios
// and randomized handshakes. Define AES_CTRL_ABORT_EN to exercise the abort input.
module tb_aes_round_ctrl;
  localparam int NR    = 14;
  localparam int SDONE = 2 * NR + 4;

  logic clk;
  logic rst;
  logic en;
`ifdef AES_CTRL_ABORT_EN
  logic abort;
`endif

  aes_round_ctrl_if bus ();

  aes_round_ctrl #(
    .NR(NR)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
`ifdef AES_CTRL_ABORT_EN
    .abort(abort),
`endif
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: position along the block's linear step sequence.
  // 0 idle, 1 load, even 2..2NR+2 key wait of round (s-2)/2, odd 3..2NR+3 round, SDONE done.
  int s;
  int checks;
  int errors;
  bit chk_on;
  int blk_cyc, first_ov, ov_cnt, ark_cnt, mix_cnt, sub_cnt, cap_cnt;

  function automatic bit is_kw(input int st);
    return st >= 2 && st <= 2 * NR + 2 && st % 2 == 0;
  endfunction

  function automatic bit is_rd(input int st);
    return st >= 3 && st <= 2 * NR + 3 && st % 2 == 1;
  endfunction

  function automatic int round_of(input int st);
    return (st - 2) / 2;
  endfunction

  function automatic logic [13:0] exp_vec(input int st, input logic e);
    logic ir, bz, ov, kr, ld, rd, sb, mx, cp;
    logic [3:0] ri;
    int r;
    r  = (st >= 2 && st < SDONE) ? round_of(st) : 0;
    ir = (st == 0);
    bz = (st != 0);
    ov = (st == SDONE);
    kr = is_kw(st);
    ri = (st == SDONE) ? 4'(NR) : 4'(r);
    ld = (st == 1) && e;
    rd = is_rd(st) && e;
    sb = rd && r >= 1;
    mx = rd && r >= 1 && r < NR;
    cp = rd && r == NR;
    return {ir, bz, ov, kr, ri, ld, sb, sb, mx, rd, cp};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cmp_cycle();
    logic [13:0] act;
    logic        e;
    e = en;
`ifdef AES_CTRL_ABORT_EN
    e = en && !abort;
`endif
    act = {bus.in_ready, bus.busy, bus.out_valid, bus.key_req, bus.round_idx, bus.dp_load,
           bus.dp_sub_en, bus.dp_shift_en, bus.dp_mix_en, bus.dp_ark_en, bus.dp_capture};
    blk_cyc++;
    if (chk_on) check("cycle_outputs", 32'(act), 32'(exp_vec(s, e)));
    ark_cnt += int'(bus.dp_ark_en);
    mix_cnt += int'(bus.dp_mix_en);
    sub_cnt += int'(bus.dp_sub_en);
    cap_cnt += int'(bus.dp_capture);
    ov_cnt  += int'(bus.out_valid);
    if (bus.out_valid && first_ov == 0) first_ov = blk_cyc;
  endtask

  task automatic model_step();
    if (rst) begin
      s = 0;
`ifdef AES_CTRL_ABORT_EN
    end else if (abort && s != 0) begin
      s = 0;
`endif
    end else if (en) begin
      if (s == 0) begin
        if (bus.in_valid) begin
          s = 1;
          blk_cyc = 0; first_ov = 0; ov_cnt = 0;
          ark_cnt = 0; mix_cnt = 0; sub_cnt = 0; cap_cnt = 0;
        end
      end else if (s == SDONE) begin
        if (bus.out_ready) s = 0;
      end else if (is_kw(s)) begin
        if (bus.key_ack) s = s + 1;
      end else begin
        s = s + 1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Runs one block from idle; negative round numbers disable the corresponding disturbance.
  task automatic run_block(input int stall_r, input int stall_n, input int gap_r,
                           input int gap_n, input int orl_n, input int rst_r,
                           input int abort_r);
    int st, gp, hd, guard;
    st = 0; gp = 0; hd = 0; guard = 0;
    rst = 1'b0; en = 1'b1;
    bus.key_ack = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    tick();
    while (s == 0 && guard < 8) begin
      tick();
      guard++;
    end
    while (s != 0 && guard < 300) begin
      bus.in_valid  = 1'($urandom);
      bus.key_ack   = 1'b1;
      bus.out_ready = 1'b1;
      en            = 1'b1;
      rst           = 1'b0;
`ifdef AES_CTRL_ABORT_EN
      abort = 1'b0;
      if (is_kw(s) && round_of(s) == abort_r) abort = 1'b1;
`endif
      if (is_kw(s) && round_of(s) == stall_r && st < stall_n) begin
        bus.key_ack = 1'b0;
        st++;
      end
      if (is_rd(s) && round_of(s) == gap_r && gp < gap_n) begin
        en = 1'b0;
        bus.key_ack = 1'($urandom);
        gp++;
      end
      if (s == SDONE && hd < orl_n) begin
        bus.out_ready = 1'b0;
        hd++;
      end
      if (is_rd(s) && round_of(s) == rst_r) rst = 1'b1;
      tick();
      guard++;
    end
    check("block_returned_to_idle", 32'(s == 0), 32'd1);
    rst = 1'b0; en = 1'b1; bus.in_valid = 1'b0;
`ifdef AES_CTRL_ABORT_EN
    abort = 1'b0;
`endif
  endtask

  initial begin
    checks = 0; errors = 0; chk_on = 1'b0; s = 0;
    blk_cyc = 0; first_ov = 0; ov_cnt = 0; ark_cnt = 0; mix_cnt = 0; sub_cnt = 0; cap_cnt = 0;
    rst = 1'b1; en = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.key_ack = 1'b0;
`ifdef AES_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    chk_on = 1'b1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_round_idx", 32'(bus.round_idx), 32'd0);
    check("reset_strobes", 32'({bus.dp_load, bus.dp_sub_en, bus.dp_shift_en, bus.dp_mix_en,
                                bus.dp_ark_en, bus.dp_capture, bus.key_req, bus.out_valid}),
          32'd0);
    tick();

    // Nominal block: ready key schedule and host.
    run_block(-1, 0, -1, 0, 0, -1, -1);
    check("nominal_out_valid_cycle", 32'(first_ov), 32'd32);
    check("nominal_ark_count", 32'(ark_cnt), 32'd15);
    check("nominal_mix_count", 32'(mix_cnt), 32'd13);
    check("nominal_sub_count", 32'(sub_cnt), 32'd14);
    check("nominal_capture_count", 32'(cap_cnt), 32'd1);

    // Key schedule stalls three cycles at round 5.
    run_block(5, 3, -1, 0, 0, -1, -1);
    check("stall_out_valid_cycle", 32'(first_ov), 32'd35);
    check("stall_ark_count", 32'(ark_cnt), 32'd15);

    // en gap of two cycles in round 7, host holds off for four cycles.
    run_block(-1, 0, 7, 2, 4, -1, -1);
    check("gap_out_valid_cycle", 32'(first_ov), 32'd34);
    check("backpressure_valid_cycles", 32'(ov_cnt), 32'd5);
    check("gap_mix_count", 32'(mix_cnt), 32'd13);

    // Reset in round 9 abandons the block; a fresh one then runs normally.
    run_block(-1, 0, -1, 0, 0, 9, -1);
    check("reset_mid_capture", 32'(cap_cnt), 32'd0);
    check("reset_mid_out_valid", 32'(ov_cnt), 32'd0);
    check("reset_mid_round_idx", 32'(bus.round_idx), 32'd0);
    check("reset_mid_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    run_block(-1, 0, -1, 0, 0, -1, -1);
    check("after_reset_out_valid_cycle", 32'(first_ov), 32'd32);

    // Abort during the round-3 key wait.
    run_block(-1, 0, -1, 0, 0, -1, 3);
`ifdef AES_CTRL_ABORT_EN
    check("abort_out_valid", 32'(ov_cnt), 32'd0);
    check("abort_capture", 32'(cap_cnt), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
`else
    check("no_abort_out_valid_cycle", 32'(first_ov), 32'd32);
    check("no_abort_capture", 32'(cap_cnt), 32'd1);
`endif

    // Randomized handshakes, enable gaps and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.key_ack   = ($urandom_range(0, 9) < 7);
      bus.out_ready = 1'($urandom_range(0, 1));
      en            = ($urandom_range(0, 9) != 0);
      rst           = ($urandom_range(0, 199) == 0);
`ifdef AES_CTRL_ABORT_EN
      abort         = ($urandom_range(0, 99) == 0);
`endif
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
